// File: rtl/clk_period_meter.sv
// clk_period_meter: measures period and high time of a slow asynchronous
// square wave in units of clk. Each completed period is offered on a single
// valid/ready holding register. A result that arrives while the register is
// still waiting to be accepted is dropped and flagged through the sticky
// overrun bit. stuck flags a missing rising edge while measuring.
module clk_period_meter #(
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned TIMEOUT = 200_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sig_in,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             overrun,
  output logic             stuck
);

  localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARM,
    ST_MEAS
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic             r_s1;
  logic             r_s2;
  logic             r_s3;
  logic             w_rise;
  logic             w_fall;

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_high_tmp;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_cnt_last;

  logic             w_cnt_clr;
  logic             w_cnt_en;
  logic             w_cap_high;
  logic             w_publish;
  logic             w_timeout;

  logic             w_accept;
  logic             w_load;
  logic             r_valid;
  logic             r_overrun;
  logic             r_stuck;
  logic [CNT_W-1:0] r_period;
  logic [CNT_W-1:0] r_high;

  // Three-stage synchroniser; s3 is kept only to detect edges on s2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= sig_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign w_rise     = r_s2 & ~r_s3;
  assign w_fall     = ~r_s2 & r_s3;
  assign w_cnt_inc  = r_cnt + CNT_W'(1);
  assign w_cnt_last = (r_cnt == LP_CNT_LAST);

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: IDLE waits for a settled low level so a partial period is never measured.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: if (!r_s2 && !r_s3)            w_state_nxt = ST_ARM;
      ST_ARM:  if (w_rise)                    w_state_nxt = ST_MEAS;
      ST_MEAS: if (!w_rise && w_cnt_last)     w_state_nxt = ST_IDLE;
      default:                                w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs: counter control, high-time capture, publish and timeout strobes.
  always_comb begin
    w_cnt_clr  = 1'b0;
    w_cnt_en   = 1'b0;
    w_cap_high = 1'b0;
    w_publish  = 1'b0;
    w_timeout  = 1'b0;
    unique case (r_state)
      ST_ARM: begin
        w_cnt_clr = w_rise;
      end
      ST_MEAS: begin
        w_cnt_en   = 1'b1;
        w_cap_high = w_fall;
        w_publish  = w_rise;
        w_timeout  = !w_rise && w_cnt_last;
        w_cnt_clr  = w_rise || w_timeout;
      end
      default: ;
    endcase
  end

  // Cycle counter since the last rising edge, and the high time of the current period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_high_tmp <= '0;
    end else begin
      if (w_cnt_clr) begin
        r_cnt <= '0;
      end else if (w_cnt_en) begin
        r_cnt <= w_cnt_inc;
      end
      if (w_cap_high) begin
        r_high_tmp <= w_cnt_inc;
      end
    end
  end

  assign w_accept = r_valid & m_ready;
  assign w_load   = w_publish & (~r_valid | m_ready);

  // Output holding register; an accept in the same cycle as an overrun wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
      r_stuck   <= 1'b0;
      r_period  <= '0;
      r_high    <= '0;
    end else begin
      if (w_load) begin
        r_valid  <= 1'b1;
        r_period <= w_cnt_inc;
        r_high   <= r_high_tmp;
      end else if (w_accept) begin
        r_valid <= 1'b0;
      end

      if (w_accept) begin
        r_overrun <= 1'b0;
      end else if (w_publish && r_valid) begin
        r_overrun <= 1'b1;
      end

      if (w_timeout) begin
        r_stuck <= 1'b1;
      end else if (w_load) begin
        r_stuck <= 1'b0;
      end
    end
  end

  assign m_valid   = r_valid;
  assign period    = r_period;
  assign high_time = r_high;
  assign overrun   = r_overrun;
  assign stuck     = r_stuck;

endmodule
